// File: rtl/demux_route_ctrl.sv
// -----------------------------------------------------------------------------
// demux_route_ctrl
// Upstream stage for demux1x2_hot_encoded. Buffers destination-tagged words in
// a small FIFO, presents the head word with a one-hot select, pops it when the
// addressed destination accepts, and keeps saturating per-destination delivery
// counters.
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset (pointers and counters)
//   flush       - synchronous FIFO clear; counters are kept
//   in_valid    - upstream word valid
//   in_ready    - block can accept a word (FIFO not full)
//   in_data     - upstream payload
//   in_dest     - destination: 0 -> out0, 1 -> out1
//   sel         - one-hot select: 01 out0, 10 out1, 00 idle
//   data_out    - head payload (zero when idle)
//   out0_ready  - destination 0 accepts this cycle
//   out1_ready  - destination 1 accepts this cycle
//   cnt0, cnt1  - saturating delivery counters
//   occupancy   - number of entries held
// -----------------------------------------------------------------------------
module demux_route_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_dest,
  output logic [1:0]                 sel,
  output logic [DATA_WIDTH-1:0]      data_out,
  input  logic                       out0_ready,
  input  logic                       out1_ready,
  output logic [CNT_WIDTH-1:0]       cnt0,
  output logic [CNT_WIDTH-1:0]       cnt1,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Each entry is {dest, data}; dest sits in the MSB.
  logic [DATA_WIDTH:0]   mem_r [DEPTH];
  logic [PW-1:0]         wp_r;
  logic [PW-1:0]         rp_r;
  logic [CNT_WIDTH-1:0]  cnt0_r;
  logic [CNT_WIDTH-1:0]  cnt1_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_WIDTH:0]   head_s;
  logic [1:0]            sel_s;
  logic [DATA_WIDTH-1:0] data_s;

  // FIFO status, head decode and handshake qualification.
  always_comb begin
    empty_s = (wp_r == rp_r);
    full_s  = (wp_r[AW] != rp_r[AW]) && (wp_r[AW-1:0] == rp_r[AW-1:0]);
    head_s  = mem_r[rp_r[AW-1:0]];
    sel_s   = 2'b00;
    data_s  = '0;
    if (empty_s) begin
      sel_s  = 2'b00;
      data_s = '0;
    end else begin
      sel_s  = head_s[DATA_WIDTH] ? 2'b10 : 2'b01;
      data_s = head_s[DATA_WIDTH-1:0];
    end
    // Only the addressed destination's ready matters (head-of-line blocking).
    pop_s  = (sel_s[0] & out0_ready) | (sel_s[1] & out1_ready);
    push_s = in_valid & ~full_s;
  end

  // Pointer update; flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_r <= '0;
      rp_r <= '0;
    end else if (flush) begin
      wp_r <= '0;
      rp_r <= '0;
    end else begin
      if (push_s) begin
        wp_r <= wp_r + PW'(1);
      end
      if (pop_s) begin
        rp_r <= rp_r + PW'(1);
      end
    end
  end

  // Payload storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wp_r[AW-1:0]] <= {in_dest, in_data};
    end
  end

  // Saturating delivery counters, bumped on a pop that is not cancelled by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= '0;
      cnt1_r <= '0;
    end else if (pop_s && !flush) begin
      if (sel_s[0] && (cnt0_r != {CNT_WIDTH{1'b1}})) begin
        cnt0_r <= cnt0_r + CNT_WIDTH'(1);
      end
      if (sel_s[1] && (cnt1_r != {CNT_WIDTH{1'b1}})) begin
        cnt1_r <= cnt1_r + CNT_WIDTH'(1);
      end
    end
  end

  // Outputs are functions of registered state only.
  always_comb begin
    in_ready  = ~full_s;
    sel       = sel_s;
    data_out  = data_s;
    cnt0      = cnt0_r;
    cnt1      = cnt1_r;
    occupancy = wp_r - rp_r;
  end

endmodule

// File: tb/tb_demux_route_ctrl.sv
module tb_demux_route_ctrl;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_dest;
  logic [1:0]    sel;
  logic [DW-1:0] data_out;
  logic          out0_ready;
  logic          out1_ready;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
  logic [2:0]    occupancy;

  int checks;
  int failures;

  demux_route_ctrl #(.DATA_WIDTH(DW), .DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_dest    (in_dest),
    .sel        (sel),
    .data_out   (data_out),
    .out0_ready (out0_ready),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .occupancy  (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [DW-1:0] d, input logic dst);
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dst;
  endtask

  logic [DW-1:0] fill_data [4];
  logic          fill_dest [4];

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_dest = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_eq("rst_sel", 32'(sel), 32'h0);
    check_eq("rst_data", 32'(data_out), 32'h0);
    check_eq("rst_in_ready", 32'(in_ready), 32'h1);
    check_eq("rst_occ", 32'(occupancy), 32'h0);
    check_eq("rst_cnt0", 32'(cnt0), 32'h0);
    check_eq("rst_cnt1", 32'(cnt1), 32'h0);

    // Routing and in-order delivery
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    offer(16'hAAAA, 1'b0);
    step();
    check_eq("route_sel0", 32'(sel), 32'h1);
    check_eq("route_data0", 32'(data_out), 32'hAAAA);
    offer(16'h5555, 1'b1);
    step();
    in_valid = 1'b0;
    check_eq("route_sel1", 32'(sel), 32'h2);
    check_eq("route_data1", 32'(data_out), 32'h5555);
    step();
    check_eq("route_idle", 32'(sel), 32'h0);
    check_eq("route_cnt0", 32'(cnt0), 32'h1);
    check_eq("route_cnt1", 32'(cnt1), 32'h1);
    check_eq("route_occ", 32'(occupancy), 32'h0);

    // Fill to full, then concurrent push and pop
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    fill_data[0] = 16'h1000; fill_dest[0] = 1'b0;
    fill_data[1] = 16'h1001; fill_dest[1] = 1'b1;
    fill_data[2] = 16'h1002; fill_dest[2] = 1'b0;
    fill_data[3] = 16'h1003; fill_dest[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(fill_data[i], fill_dest[i]);
      step();
    end
    check_eq("full_in_ready", 32'(in_ready), 32'h0);
    check_eq("full_occ", 32'(occupancy), 32'h4);
    check_eq("full_head_sel", 32'(sel), 32'h1);
    check_eq("full_head_data", 32'(data_out), 32'h1000);
    offer(16'h2222, 1'b1);
    step();
    check_eq("full_reject_occ", 32'(occupancy), 32'h4);
    check_eq("full_hold_data", 32'(data_out), 32'h1000);
    out0_ready = 1'b1;
    step();
    out0_ready = 1'b0;
    check_eq("pop_occ", 32'(occupancy), 32'h3);
    check_eq("pop_next_data", 32'(data_out), 32'h1001);
    check_eq("pop_in_ready", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    check_eq("fifth_occ", 32'(occupancy), 32'h4);
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    check_eq("drain_d0", 32'(data_out), 32'h1001);
    step();
    check_eq("drain_d1", 32'(data_out), 32'h1002);
    check_eq("drain_s1", 32'(sel), 32'h1);
    step();
    check_eq("drain_d2", 32'(data_out), 32'h1003);
    step();
    check_eq("drain_d3", 32'(data_out), 32'h2222);
    check_eq("drain_s3", 32'(sel), 32'h2);
    step();
    check_eq("drain_occ", 32'(occupancy), 32'h0);
    check_eq("drain_cnt0", 32'(cnt0), 32'h3);
    check_eq("drain_cnt1", 32'(cnt1), 32'h4);

    // Head-of-line blocking (counters cleared first)
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    check_eq("hol_cnt0_clr", 32'(cnt0), 32'h0);
    offer(16'hB001, 1'b1);
    step();
    offer(16'hB000, 1'b0);
    step();
    in_valid = 1'b0;
    out0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_eq("hol_sel", 32'(sel), 32'h2);
      check_eq("hol_occ", 32'(occupancy), 32'h2);
      check_eq("hol_cnt0", 32'(cnt0), 32'h0);
      step();
    end
    out1_ready = 1'b1;
    step();
    check_eq("hol_cnt1", 32'(cnt1), 32'h1);
    check_eq("hol_cnt0_after", 32'(cnt0), 32'h0);
    check_eq("hol_sel_next", 32'(sel), 32'h1);
    check_eq("hol_data_next", 32'(data_out), 32'hB000);
    step();
    check_eq("hol_cnt0_final", 32'(cnt0), 32'h1);
    check_eq("hol_occ_final", 32'(occupancy), 32'h0);

    // Flush with concurrent push and pop
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    offer(16'hC000, 1'b0);
    step();
    offer(16'hC001, 1'b1);
    step();
    offer(16'hC002, 1'b0);
    step();
    check_eq("pre_flush_occ", 32'(occupancy), 32'h3);
    offer(16'hC003, 1'b1);
    out0_ready = 1'b1;
    flush = 1'b1;
    check_eq("flush_in_ready", 32'(in_ready), 32'h1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out0_ready = 1'b0;
    check_eq("flush_occ", 32'(occupancy), 32'h0);
    check_eq("flush_sel", 32'(sel), 32'h0);
    check_eq("flush_data", 32'(data_out), 32'h0);
    check_eq("flush_cnt0", 32'(cnt0), 32'h1);
    check_eq("flush_cnt1", 32'(cnt1), 32'h1);

    // Mid-cycle asynchronous reset
    offer(16'hD000, 1'b1);
    step();
    offer(16'hD001, 1'b0);
    step();
    in_valid = 1'b0;
    check_eq("prerst_occ", 32'(occupancy), 32'h2);
    check_eq("prerst_sel", 32'(sel), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_sel", 32'(sel), 32'h0);
    check_eq("arst_data", 32'(data_out), 32'h0);
    check_eq("arst_in_ready", 32'(in_ready), 32'h1);
    check_eq("arst_occ", 32'(occupancy), 32'h0);
    check_eq("arst_cnt0", 32'(cnt0), 32'h0);
    check_eq("arst_cnt1", 32'(cnt1), 32'h0);
    #1;
    rst_n = 1'b1;
    step();

    // Counter saturation: 17 back-to-back words to dest 0
    out0_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      offer(16'(16'hE000 + i), 1'b0);
      step();
    end
    in_valid = 1'b0;
    step();
    check_eq("sat_occ", 32'(occupancy), 32'h0);
    check_eq("sat_cnt0", 32'(cnt0), 32'hF);
    check_eq("sat_cnt1", 32'(cnt1), 32'h0);
    offer(16'hF000, 1'b0);
    step();
    offer(16'hF001, 1'b0);
    step();
    in_valid = 1'b0;
    step();
    check_eq("sat_hold_cnt0", 32'(cnt0), 32'hF);
    check_eq("sat_hold_occ", 32'(occupancy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
